// File: rtl/alu_op_fifo.sv
// First-word-fall-through queue of ALU operations (a, b, ctrl) between decode and the ALU.
// Optional ALU_OP_FIFO_CTRL_CHECK_EN drops pushes with unknown control codes and flags them.
module alu_op_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic [3:0]                 in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_a,
    output logic [31:0]                out_b,
    output logic [3:0]                 out_ctrl,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       illegal_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [67:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_store;
    logic          w_legal;
    logic [67:0]   w_head;

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    // Flush wins over both handshakes in the same cycle.
    assign w_push  = in_valid && in_ready && !flush;
    assign w_pop   = out_valid && out_ready && !flush;
    assign w_store = w_push && w_legal;

`ifdef ALU_OP_FIFO_CTRL_CHECK_EN
    logic r_illegal;

    always_comb begin
        w_legal = 1'b0;
        case (in_ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0101, 4'b0110, 4'b0111: w_legal = 1'b1;
            default:                            w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_illegal <= 1'b0;
        end else if (w_push && !w_legal) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_flag = r_illegal;
`else
    assign w_legal      = 1'b1;
    assign illegal_flag = 1'b0;
`endif

    // Storage is not reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wptr] <= {in_a, in_b, in_ctrl};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head   = out_valid ? r_mem[r_rptr] : '0;
    assign out_a    = w_head[67:36];
    assign out_b    = w_head[35:4];
    assign out_ctrl = w_head[3:0];

endmodule

// File: tb/tb_alu_op_fifo.sv
// Directed self-checking bench for alu_op_fifo (DEPTH=4).
// Expectations follow ALU_OP_FIFO_CTRL_CHECK_EN when it is defined.
module tb_alu_op_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_ctrl;
    logic [2:0]  count;
    logic        illegal_flag;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] lg [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'h7};

    alu_op_fifo #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl),
        .count(count), .illegal_flag(illegal_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] c);
        check({tag, "_a"}, out_a, a);
        check({tag, "_b"}, out_b, b);
        check({tag, "_ctrl"}, out_ctrl, c);
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_ctrl  = c;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        #12;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check_head("rst_head", 0, 0, 0);
        check("rst_illegal", illegal_flag, 0);
        tick();
        rst = 1'b0;

        // fill / drain
        drive(1'b1, 32'd1, 32'd2, 4'b0010);
        tick();
        check("fill1_count", count, 1);
        check_head("fill1_head", 1, 2, 4'b0010);
        drive(1'b1, 32'd3, 32'd4, 4'b0100);
        tick();
        check("fill2_count", count, 2);
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        out_ready = 1'b1;
        check_head("drain1_head", 1, 2, 4'b0010);
        tick();
        check("drain1_count", count, 1);
        check_head("drain2_head", 3, 4, 4'b0100);
        tick();
        check("drain2_count", count, 0);
        check("drain_out_valid", out_valid, 0);
        check_head("empty_head", 0, 0, 0);

        // full
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i), 32'(100 + i), 4'(i));
            tick();
        end
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        drive(1'b1, 32'd5, 32'd105, 4'd5);
        out_ready = 1'b1;
        tick();
        check("refuse_count", count, 3);
        check_head("refuse_head", 1, 101, 4'd1);
        check("refuse_in_ready", in_ready, 1);
        out_ready = 1'b0;
        tick();
        check("accept5_count", count, 4);
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        out_ready = 1'b1;
        check_head("fd1", 1, 101, 4'd1);
        tick();
        check_head("fd2", 2, 102, 4'd2);
        tick();
        check_head("fd3", 3, 103, 4'd3);
        tick();
        check_head("fd5", 5, 105, 4'd5);
        tick();
        check("full_drained", count, 0);

        // wrap with simultaneous push/pop
        out_ready = 1'b0;
        drive(1'b1, 32'd200, 32'd300, lg[0]);
        tick();
        check("wrap_start_count", count, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'(200 + i), 32'(300 + i), lg[i % 9]);
            check_head("wrap_head", 32'(200 + i - 1), 32'(300 + i - 1), lg[(i - 1) % 9]);
            tick();
            check("wrap_count", count, 1);
        end
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        check_head("wrap_last", 210, 310, lg[1]);
        tick();
        check("wrap_drained", count, 0);

        // flush while pushing
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(40 + i), 32'(50 + i), 4'd1);
            tick();
        end
        check("pre_flush_count", count, 3);
        flush = 1'b1;
        drive(1'b1, 32'd77, 32'd78, 4'd2);
        check("flush_in_ready", in_ready, 1);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        check_head("flush_head", 0, 0, 0);
        tick();
        check("flush_dropped", count, 0);

        // asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(60 + i), 32'(70 + i), 4'd4);
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        check("pre_rst_count", count, 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_out_valid", out_valid, 0);
        check_head("arst_head", 0, 0, 0);
        #1;
        rst = 1'b0;
        drive(1'b1, 32'd9, 32'd8, 4'd7);
        tick();
        check("post_rst_push", count, 1);
        check_head("post_rst_head", 9, 8, 4'd7);
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // illegal control code
        drive(1'b1, 32'd11, 32'd12, 4'b1111);
        check("ill_in_ready", in_ready, 1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 4'd0);
`ifdef ALU_OP_FIFO_CTRL_CHECK_EN
        check("ill_count", count, 0);
        check("ill_flag", illegal_flag, 1);
        tick();
        check("ill_flag_sticky", illegal_flag, 1);
`else
        check("ill_count", count, 1);
        check("ill_flag", illegal_flag, 0);
        check_head("ill_head", 11, 12, 4'b1111);
        tick();
        check("ill_flag_idle", illegal_flag, 0);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("ill_flush_flag", illegal_flag, 0);
        check("ill_flush_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_fifo.md
ALU_OP_FIFO -- requirements
Module: alu_op_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queued operation entries; it must be a power of two, at least 2.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 Port flush SHALL be an input, 1 bit wide: synchronous discard of all queued entries.
REQ-006 Port in_valid SHALL be an input, 1 bit wide: upstream (decode) offers an operation.
REQ-007 Port in_ready SHALL be an output, 1 bit wide: the queue can accept an operation.
REQ-008 Port in_a SHALL be an input, 32 bits wide: operand 1.
REQ-009 Port in_b SHALL be an input, 32 bits wide: operand 2.
REQ-010 Port in_ctrl SHALL be an input, 4 bits wide: the 4-bit ALU control code.
REQ-011 Port out_valid SHALL be an output, 1 bit wide: the head entry is presented to the ALU.
REQ-012 Port out_ready SHALL be an input, 1 bit wide: the ALU consumes the head entry.
REQ-013 Port out_a SHALL be an output, 32 bits wide: head operand 1.
REQ-014 Port out_b SHALL be an output, 32 bits wide: head operand 2.
REQ-015 Port out_ctrl SHALL be an output, 4 bits wide: head control code.
REQ-016 Port count SHALL be an output, $clog2(DEPTH)+1 bits wide: the number of entries held.
REQ-017 Port illegal_flag SHALL be an output, 1 bit wide: sticky flag for a rejected control code.

Function
REQ-018 A push SHALL occur on a rising edge where in_valid && in_ready; a pop SHALL occur where out_valid && out_ready.
REQ-019 in_ready SHALL equal (count != DEPTH), with no dependence on out_ready: a full queue refuses a push even in a pop cycle.
REQ-020 out_valid SHALL equal (count != 0).
REQ-021 The queue SHALL be first-word-fall-through: an entry pushed at edge N appears on out_* after edge N, so it is poppable in cycle N+1; there is no same-cycle in-to-out bypass.
REQ-022 While count == 0, out_a, out_b and out_ctrl SHALL drive 0.
REQ-023 On a push alone, count SHALL increase by 1; on a pop alone, count SHALL decrease by 1; on a simultaneous push and pop (only possible when 0 < count < DEPTH), count SHALL stay unchanged and both actions SHALL take effect.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO across wrap-around.
REQ-025 Entry width SHALL be 68 bits (a, b, ctrl); data SHALL be stored and returned unmodified.
REQ-026 When flush is high, count and both pointers SHALL go to 0 at that edge; any push or pop in the same cycle SHALL be ignored (flush wins); illegal_flag SHALL clear.
REQ-027 in_ready SHALL remain 1 during flush if the queue is not full, but a push offered in a flush cycle SHALL be dropped.

Reset
REQ-028 While rst is high, the block SHALL hold: count=0, pointers=0, out_valid=0, in_ready=1, out_a/out_b/out_ctrl=0, illegal_flag=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously); storage contents need not be cleared.
REQ-030 After rst deasserts, the first push SHALL be accepted on the first rising edge.

Configuration
REQ-031 Macro ALU_OP_FIFO_CTRL_CHECK_EN, when defined, SHALL make a push with in_ctrl outside {0000,0001,0010,0100,1000,0011,0101,0110,0111} complete its handshake but not be stored (count unchanged).
REQ-032 With ALU_OP_FIFO_CTRL_CHECK_EN defined, such a push SHALL set illegal_flag, which stays set until rst or flush.
REQ-033 Without ALU_OP_FIFO_CTRL_CHECK_EN, every code SHALL be stored and illegal_flag SHALL be tied to 0.

Verification
REQ-034 Fill/drain: push A=1,B=2,ctrl=0010, then A=3,B=4,ctrl=0100, with out_ready=0 -> count=2; raise out_ready -> pops in order (1,2,0010) then (3,4,0100); empty -> out_*=0.
REQ-035 Full: with DEPTH=4, do 4 pushes, then a 5th offer with out_ready=1 -> in_ready=0, so the 5th is refused that cycle and accepted the next cycle; count peaks at 4.
REQ-036 Wrap and simultaneous: stream 10 operations with continuous push and pop at count=1 -> count stays 1 and the output order matches input across pointer wrap.
REQ-037 Flush/reset: with 3 entries queued, assert flush while pushing -> count=0 and out_valid=0 next cycle; repeat with async rst mid-cycle -> outputs zero before the next edge.
REQ-038 Macro: with the macro defined, push ctrl=1111 -> handshake completes, count unchanged, illegal_flag=1 until flush; without the macro, the same push -> stored, count+1, illegal_flag=0.
